// File: rtl/batt_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : batt_supervisor
// Purpose  : Battery supervisor. It filters each new battery conversion with a
//            first-order IIR filter. It then classifies the filtered level into
//            NORM / WARN / CRIT, using hysteresis and consecutive-sample
//            debounce. A sustained critical level escalates to a latched
//            shutdown request.
// Ports    : clk        - system clock
//            rst        - asynchronous, active-high reset
//            en         - power-up enable; low forces INIT and clears outputs
//            smpl_vld   - one-cycle strobe, batt holds a new conversion
//            batt       - raw battery reading [WIDTH]
//            filt_batt  - filtered battery value, registered [WIDTH]
//            batt_low   - state is WARN, CRIT or SHUTDN
//            batt_crit  - state is CRIT or SHUTDN
//            shutdn_req - state is SHUTDN (sticky until en=0 or rst)
//            min_batt   - minimum filtered value since last INIT [WIDTH]
//                         (only present with BATT_SUPERVISOR_MINCAP_EN)
// Options  : `define BATT_SUPERVISOR_MINCAP_EN adds the min_batt capture.
// Revision : 1.0 - initial release
// ============================================================================
module batt_supervisor #(
   parameter int               WIDTH       = 12,
   parameter logic [WIDTH-1:0] WARN_THRESH = 12'h800,
   parameter logic [WIDTH-1:0] CRIT_THRESH = 12'h700,
   parameter logic [WIDTH-1:0] HYST        = 12'h040,
   parameter int               DEB_CNT     = 4,
   parameter int               SHUT_CNT    = 16,
   parameter int               AVG_SHIFT   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             smpl_vld,
   input  logic [WIDTH-1:0] batt,
   output logic [WIDTH-1:0] filt_batt,
   output logic             batt_low,
   output logic             batt_crit,
   output logic             shutdn_req
`ifdef BATT_SUPERVISOR_MINCAP_EN
   ,
   output logic [WIDTH-1:0] min_batt
`endif
);

   localparam int DEB_W  = $clog2(DEB_CNT + 1);
   localparam int SHUT_W = $clog2(SHUT_CNT + 1);

   localparam logic [DEB_W-1:0]  C_DEB_MAX  = DEB_W'(DEB_CNT);
   localparam logic [SHUT_W-1:0] C_SHUT_MAX = SHUT_W'(SHUT_CNT);

   // Recovery levels are kept one bit wider than the data. If a sum exceeds
   // full scale, no sample can ever reach it.
   localparam logic [WIDTH:0] C_WARN_EXIT = {1'b0, WARN_THRESH} + {1'b0, HYST};
   localparam logic [WIDTH:0] C_CRIT_EXIT = {1'b0, CRIT_THRESH} + {1'b0, HYST};

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_NORM   = 3'd1,
      S_WARN   = 3'd2,
      S_CRIT   = 3'd3,
      S_SHUTDN = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   filt_q,  filt_d;
   logic [DEB_W-1:0]   deb_q,   deb_d;
   logic [SHUT_W-1:0]  shut_q,  shut_d;

   logic signed [WIDTH:0] diff_w;
   logic signed [WIDTH:0] step_w;
   logic signed [WIDTH:0] sum_w;
   logic [WIDTH-1:0]      f_new_w;
   logic                  lt_warn_w;
   logic                  lt_crit_w;
   logic                  ge_warn_exit_w;
   logic                  ge_crit_exit_w;
   logic [DEB_W-1:0]      deb_inc_w;
   logic [SHUT_W-1:0]     shut_inc_w;

   // ------------------------------------------------------------------------
   // IIR filter. The arithmetic shift of the signed difference keeps the
   // result between the old filtered value and the new sample, so the sum
   // always fits in WIDTH bits.
   // ------------------------------------------------------------------------
   always_comb begin
      diff_w  = $signed({1'b0, batt}) - $signed({1'b0, filt_q});
      step_w  = diff_w >>> AVG_SHIFT;
      sum_w   = $signed({1'b0, filt_q}) + step_w;
      f_new_w = (state_q == S_INIT) ? batt : sum_w[WIDTH-1:0];
   end

   assign lt_warn_w      = (f_new_w < WARN_THRESH);
   assign lt_crit_w      = (f_new_w < CRIT_THRESH);
   assign ge_warn_exit_w = ({1'b0, f_new_w} >= C_WARN_EXIT);
   assign ge_crit_exit_w = ({1'b0, f_new_w} >= C_CRIT_EXIT);

   // While a count is running, deb_q stays below DEB_CNT and shut_q stays
   // below SHUT_CNT, so these increments never wrap.
   assign deb_inc_w  = deb_q + DEB_W'(1);
   assign shut_inc_w = shut_q + SHUT_W'(1);

`ifdef BATT_SUPERVISOR_MINCAP_EN
   logic [WIDTH-1:0] min_q, min_d;

   always_comb begin
      min_d = min_q;
      if (!en) begin
         min_d = '1;
      end else if (smpl_vld) begin
         if (state_q == S_INIT || f_new_w < min_q) begin
            min_d = f_new_w;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_q <= '1;
      end else begin
         min_q <= min_d;
      end
   end

   assign min_batt = min_q;
`endif

   // ------------------------------------------------------------------------
   // Next-state logic. The debounce counter counts consecutive samples that
   // qualify for some exit from the current state. In WARN, the CRIT
   // condition decides the target when both could apply.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      filt_d  = filt_q;
      deb_d   = deb_q;
      shut_d  = shut_q;

      if (!en) begin
         state_d = S_INIT;
         filt_d  = '0;
         deb_d   = '0;
         shut_d  = '0;
      end else if (smpl_vld) begin
         filt_d = f_new_w;
         unique case (state_q)
            S_INIT: begin
               state_d = S_NORM;
               deb_d   = '0;
               shut_d  = '0;
            end
            S_NORM: begin
               if (lt_warn_w) begin
                  if (deb_inc_w == C_DEB_MAX) begin
                     state_d = S_WARN;
                     deb_d   = '0;
                  end else begin
                     deb_d = deb_inc_w;
                  end
               end else begin
                  deb_d = '0;
               end
            end
            S_WARN: begin
               if (lt_crit_w || ge_warn_exit_w) begin
                  if (deb_inc_w == C_DEB_MAX) begin
                     state_d = lt_crit_w ? S_CRIT : S_NORM;
                     deb_d   = '0;
                  end else begin
                     deb_d = deb_inc_w;
                  end
               end else begin
                  deb_d = '0;
               end
            end
            S_CRIT: begin
               if (lt_crit_w) begin
                  deb_d = '0;
                  if (shut_inc_w == C_SHUT_MAX) begin
                     state_d = S_SHUTDN;
                     shut_d  = '0;
                  end else begin
                     shut_d = shut_inc_w;
                  end
               end else begin
                  shut_d = '0;
                  if (ge_crit_exit_w) begin
                     if (deb_inc_w == C_DEB_MAX) begin
                        state_d = S_WARN;
                        deb_d   = '0;
                     end else begin
                        deb_d = deb_inc_w;
                     end
                  end else begin
                     deb_d = '0;
                  end
               end
            end
            S_SHUTDN: begin
               deb_d  = '0;
               shut_d = '0;
            end
            default: begin
               state_d = S_INIT;
               deb_d   = '0;
               shut_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
         filt_q  <= '0;
         deb_q   <= '0;
         shut_q  <= '0;
      end else begin
         state_q <= state_d;
         filt_q  <= filt_d;
         deb_q   <= deb_d;
         shut_q  <= shut_d;
      end
   end

   // The flags are decoded from the registered state only.
   assign filt_batt  = filt_q;
   assign batt_low   = (state_q == S_WARN) || (state_q == S_CRIT) || (state_q == S_SHUTDN);
   assign batt_crit  = (state_q == S_CRIT) || (state_q == S_SHUTDN);
   assign shutdn_req = (state_q == S_SHUTDN);

endmodule
`default_nettype wire

// File: tb/tb_batt_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_batt_supervisor
// Purpose  : Self-checking bench for batt_supervisor. It drives two instances
//            (AVG_SHIFT=0 and AVG_SHIFT=2) with shared directed and random
//            stimulus. Each instance is compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_batt_supervisor;

   localparam int W     = 12;
   localparam int WARN  = 'h800;
   localparam int CRIT  = 'h700;
   localparam int HYS   = 'h040;
   localparam int DEB   = 4;
   localparam int SHUT  = 16;

   // Model state codes
   localparam int M_INIT = 0, M_NORM = 1, M_WARN = 2, M_CRIT = 3, M_SHUT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          smpl_vld;
   logic [W-1:0]  batt;
   logic [W-1:0]  filt_o [2];
   logic          low_o  [2];
   logic          crit_o [2];
   logic          shut_o [2];
`ifdef BATT_SUPERVISOR_MINCAP_EN
   logic [W-1:0]  min_o  [2];
`endif

   int n_chk = 0;
   int n_err = 0;

   int m_st   [2];
   int m_filt [2];
   int m_deb  [2];
   int m_shut [2];
   int m_min  [2];
   int m_sh   [2];

   always #5 clk = ~clk;

   batt_supervisor #(
      .WIDTH(W), .WARN_THRESH(12'h800), .CRIT_THRESH(12'h700), .HYST(12'h040),
      .DEB_CNT(DEB), .SHUT_CNT(SHUT), .AVG_SHIFT(0)
   ) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .smpl_vld(smpl_vld), .batt(batt),
      .filt_batt(filt_o[0]), .batt_low(low_o[0]), .batt_crit(crit_o[0]),
      .shutdn_req(shut_o[0])
`ifdef BATT_SUPERVISOR_MINCAP_EN
      , .min_batt(min_o[0])
`endif
   );

   batt_supervisor #(
      .WIDTH(W), .WARN_THRESH(12'h800), .CRIT_THRESH(12'h700), .HYST(12'h040),
      .DEB_CNT(DEB), .SHUT_CNT(SHUT), .AVG_SHIFT(2)
   ) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .smpl_vld(smpl_vld), .batt(batt),
      .filt_batt(filt_o[1]), .batt_low(low_o[1]), .batt_crit(crit_o[1]),
      .shutdn_req(shut_o[1])
`ifdef BATT_SUPERVISOR_MINCAP_EN
      , .min_batt(min_o[1])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int floor_div_pow2(input int d, input int sh);
      int p;
      p = 1 << sh;
      if (d >= 0) return d / p;
      return -((-d + p - 1) / p);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = M_INIT; m_filt[k] = 0; m_deb[k] = 0; m_shut[k] = 0; m_min[k] = 'hFFF;
      end
   endtask

   // One clock edge of behaviour for instance k.
   task automatic model_step(input int k, input bit e, input bit v, input int b);
      int f;
      int tgt;
      if (!e) begin
         m_st[k] = M_INIT; m_filt[k] = 0; m_deb[k] = 0; m_shut[k] = 0; m_min[k] = 'hFFF;
         return;
      end
      if (!v) return;
      if (m_st[k] == M_INIT) begin
         m_filt[k] = b; m_min[k] = b; m_st[k] = M_NORM; m_deb[k] = 0; m_shut[k] = 0;
         return;
      end
      f = m_filt[k] + floor_div_pow2(b - m_filt[k], m_sh[k]);
      m_filt[k] = f;
      if (f < m_min[k]) m_min[k] = f;
      tgt = -1;
      case (m_st[k])
         M_NORM: if (f < WARN) tgt = M_WARN;
         M_WARN: begin
            if (f < CRIT) tgt = M_CRIT;
            else if (f >= WARN + HYS) tgt = M_NORM;
         end
         M_CRIT: begin
            if (f < CRIT) begin
               m_shut[k]++;
               if (m_shut[k] == SHUT) begin
                  m_st[k] = M_SHUT; m_shut[k] = 0; m_deb[k] = 0;
                  return;
               end
            end else begin
               m_shut[k] = 0;
            end
            if (f >= CRIT + HYS) tgt = M_WARN;
         end
         default: ;
      endcase
      if (tgt < 0) begin
         m_deb[k] = 0;
      end else begin
         m_deb[k]++;
         if (m_deb[k] == DEB) begin
            m_st[k] = tgt; m_deb[k] = 0; m_shut[k] = 0;
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("filt%0d", k), 32'(filt_o[k]), 32'(m_filt[k]));
         chk($sformatf("low%0d", k),  32'(low_o[k]),
             32'(m_st[k] == M_WARN || m_st[k] == M_CRIT || m_st[k] == M_SHUT));
         chk($sformatf("crit%0d", k), 32'(crit_o[k]), 32'(m_st[k] == M_CRIT || m_st[k] == M_SHUT));
         chk($sformatf("shut%0d", k), 32'(shut_o[k]), 32'(m_st[k] == M_SHUT));
`ifdef BATT_SUPERVISOR_MINCAP_EN
         chk($sformatf("min%0d", k),  32'(min_o[k]),  32'(m_min[k]));
`endif
      end
   endtask

   // Called at a negedge. Drives inputs, steps the model on the posedge, and
   // compares at the following negedge.
   task automatic step(input bit e, input bit v, input int b);
      en = e; smpl_vld = v; batt = W'(b);
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, e, v, b);
      @(negedge clk);
      smpl_vld = 1'b0;
      compare_all();
   endtask

   task automatic samp(input int b);
      step(1'b1, 1'b1, b);
   endtask

   initial begin
      int lvl;
      int hold;
      m_sh[0] = 0; m_sh[1] = 2;
      model_reset();
      rst = 1'b1; en = 1'b0; smpl_vld = 1'b0; batt = '0;
      repeat (3) @(negedge clk);
      chk("rst_filt", 32'(filt_o[0]), 0);
      chk("rst_low",  32'(low_o[0]),  0);
      chk("rst_shut", 32'(shut_o[1]), 0);
`ifdef BATT_SUPERVISOR_MINCAP_EN
      chk("rst_min",  32'(min_o[0]), 'hFFF);
`endif
      rst = 1'b0;
      step(1'b1, 1'b0, 0);

      // Three low samples then a good one: the debounce count is lost.
      samp('h900);
      repeat (3) samp('h7F0);
      samp('h900);
      chk("deb_clear_low", 32'(low_o[0]), 0);
      step(1'b1, 1'b0, 0);
      repeat (3) samp('h7F0);
      chk("deb3_low", 32'(low_o[0]), 0);
      samp('h7F0);
      chk("deb4_low", 32'(low_o[0]), 1);

      // Inside the hysteresis band WARN is held; at the exit level it recovers.
      repeat (10) samp('h820);
      chk("hyst_hold", 32'(low_o[0]), 1);
      repeat (3) samp('h840);
      chk("hyst_exit3", 32'(low_o[0]), 1);
      samp('h840);
      chk("hyst_exit4", 32'(low_o[0]), 0);

      // Sustained low level escalates to shutdown at the 24th sample.
      repeat (8) samp('h100);
      chk("crit_at8", 32'(crit_o[0]), 1);
      repeat (15) samp('h100);
      chk("shut_at23", 32'(shut_o[0]), 0);
      samp('h100);
      chk("shut_at24", 32'(shut_o[0]), 1);
      repeat (6) samp('hFFF);
      chk("shut_sticky", 32'(shut_o[0]), 1);

      // Dropping en clears everything; the next sample restarts in NORM.
      step(1'b0, 1'b0, 0);
      chk("endrop_shut", 32'(shut_o[0]), 0);
      chk("endrop_filt", 32'(filt_o[0]), 0);
      samp('hA00);
      chk("restart_filt", 32'(filt_o[0]), 'hA00);
      chk("restart_low", 32'(low_o[0]), 0);

      // en drop in the middle of a WARN->CRIT debounce, with a coincident strobe.
      repeat (4) samp('h7F0);
      repeat (2) samp('h100);
      step(1'b0, 1'b1, 'h100);
      chk("middeb_low", 32'(low_o[0]), 0);
      chk("middeb_filt", 32'(filt_o[1]), 0);
      samp('hA00);
      chk("middeb_restart", 32'(filt_o[1]), 'hA00);

      // Filter step response with AVG_SHIFT=2.
      step(1'b0, 1'b0, 0);
      samp('h800);
      samp('h000);
      chk("iir_1", 32'(filt_o[1]), 'h600);
      samp('h000);
      chk("iir_2", 32'(filt_o[1]), 'h480);
      samp('h000);
      chk("iir_3", 32'(filt_o[1]), 'h360);

`ifdef BATT_SUPERVISOR_MINCAP_EN
      step(1'b0, 1'b0, 0);
      samp('h900); samp('h750); samp('h880);
      chk("min_cap", 32'(min_o[0]), 'h750);
      step(1'b0, 1'b0, 0);
      chk("min_clear", 32'(min_o[0]), 'hFFF);
`endif

      // Random segments of held levels, sparse strobes, occasional en drops.
      hold = 0; lvl = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            hold = $urandom_range(1, 40);
            case ($urandom_range(0, 3))
               0:       lvl = $urandom_range(0, 'hFFF);
               1:       lvl = $urandom_range(0, 'h6FF);
               default: lvl = $urandom_range('h6C0, 'h880);
            endcase
         end
         if ($urandom_range(0, 199) == 0) begin
            step(1'b0, $urandom_range(0, 1) == 1, lvl);
         end else if ($urandom_range(0, 3) != 0) begin
            samp(lvl);
            hold--;
         end else begin
            step(1'b1, 1'b0, $urandom_range(0, 'hFFF));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/batt_supervisor.md
Name: batt_supervisor

Overview:
- Parametrised successor to the core's single-compare battery-low flag.
- Sits between the A2D interface and the piezo driver / balance control, and is clocked by the same strobe that requests new conversions.
- Filters the battery reading with a first-order IIR filter and classifies it into NORM/WARN/CRIT with hysteresis and consecutive-sample debounce.
- Escalates a sustained critical level to a latched shutdown request.

Parameters:
- WIDTH, 12: battery sample and threshold width.
- WARN_THRESH, 12'h800: warn level; filtered value strictly below this qualifies as low.
- CRIT_THRESH, 12'h700: critical level; must be below WARN_THRESH.
- HYST, 12'h040: recovery margin added to a threshold when exiting a state.
- DEB_CNT, 4: consecutive qualifying samples (>=1) needed for any state change.
- SHUT_CNT, 16: consecutive sub-CRIT samples in CRIT that trigger SHUTDN.
- AVG_SHIFT, 2: IIR shift; 0 means unfiltered pass-through.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  pwr_up from auth block; low forces INIT and clears all outputs.
- smpl_vld  in  1  one-cycle strobe: batt holds a new conversion.
- batt  in  WIDTH  raw battery reading.
- filt_batt  out  WIDTH  filtered battery value (registered).
- batt_low  out  1  state is WARN, CRIT or SHUTDN.
- batt_crit  out  1  state is CRIT or SHUTDN.
- shutdn_req  out  1  state is SHUTDN.

Behaviour:
- Reset: state=INIT, filt_batt=0, debounce counter=0, shutdown counter=0, all flags 0.
- Samples are processed only when en=1 and smpl_vld=1. All other cycles hold every register.
- Filter: on the first sample after INIT, f_new=batt. Otherwise f_new = filt + ((batt - filt) >>> AVG_SHIFT), computed signed in WIDTH+1 bits. The result always lies in [0, 2^WIDTH-1]; no saturation is needed.
- filt_batt<=f_new at the sampling edge. Classification uses f_new in the same edge, so the flags are registered one cycle after the qualifying smpl_vld.
- Threshold+HYST is compared in WIDTH+1 bits. A sum above full-scale can never be met, so that state cannot be exited by recovery.
- FSM states: INIT, NORM, WARN, CRIT, SHUTDN.
  - INIT: the first sample goes directly to NORM; no debounce is applied.
  - NORM->WARN: f_new < WARN_THRESH on DEB_CNT consecutive samples.
  - WARN->NORM: f_new >= WARN_THRESH+HYST on DEB_CNT consecutive samples.
  - WARN->CRIT: f_new < CRIT_THRESH on DEB_CNT consecutive samples.
  - CRIT->WARN: f_new >= CRIT_THRESH+HYST on DEB_CNT consecutive samples.
  - NORM never jumps directly to CRIT; it passes through WARN.
- Debounce counter:
  - Counts consecutive samples qualifying for the pending transition.
  - Clears on any non-qualifying sample and on every state change.
  - In WARN, the CRIT condition has priority over the NORM condition.
  - A sample meeting neither clears the counter.
  - Width is $clog2(DEB_CNT+1).
- Shutdown counter:
  - In CRIT, increments on each sample with f_new < CRIT_THRESH; any other sample clears it.
  - Reaching SHUT_CNT gives CRIT->SHUTDN, which has priority over CRIT->WARN on the same sample.
- SHUTDN is sticky. Only en=0 or rst leaves it.
- en falling (any state, mid-debounce included): the next edge sets state=INIT, clears both counters and all flags, and sets filt_batt=0. A smpl_vld coincident with en=0 is ignored.
- Outputs are decoded from registered state only; they are glitch-free.

Optional Feature:
- Macro BATT_SUPERVISOR_MINCAP_EN.
- When defined:
  - Adds output port min_batt [WIDTH].
  - min_batt is the minimum of all f_new values since the last INIT.
  - It is loaded with f_new on the INIT sample and updated as min(min_batt, f_new) on each processed sample.
  - It resets to all ones and returns to all ones when en=0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- AVG_SHIFT=0, DEB_CNT=4. Sample 12'h900, then 12'h7F0 x3, then 12'h900 -> batt_low stays 0 and state is NORM (debounce cleared). Then 12'h7F0 x4 -> batt_low=1 one cycle after the 4th strobe.
- From WARN, samples at 12'h820 x10 -> stays WARN (below 12'h840 hysteresis). Then 12'h840 x4 -> batt_low=0.
- AVG_SHIFT=2, filt=12'h800, batt=12'h000 -> filt_batt sequence 12'h600, 12'h480, 12'h360.
- AVG_SHIFT=0. NORM, then 12'h100 sustained -> WARN after 4 samples, CRIT after 8, shutdn_req=1 after 24. Raising batt to 12'hFFF keeps shutdn_req=1.
- In SHUTDN (and separately mid-debounce in WARN), drop en for 1 cycle -> all flags 0, filt_batt=0. The next sample 12'hA00 gives NORM with filt_batt=12'hA00.
- Macro defined: samples 12'h900, 12'h750, 12'h880 -> min_batt=12'h750. en=0 -> min_batt=12'hFFF.
